ifu_bpu_gen2: RTL and testbench

Second-generation IFU branch prediction unit. It keeps the static rules for JAL, JALR and backward-branch-taken, and adds three things:
- a parametrised branch history table (BHT) of 2-bit saturating counters for conditional branches;
- a circular return address stack (RAS) for call/return prediction;
- an explicit register-read state machine, with dependency stall, for JALR through a general register.

It sits between the IFU mini-decoder and the IFU PC adder. It outputs the two adder operands and the taken flag in the same cycle as decode.

---
 rtl/ifu_bpu_gen2.sv | 213 +++++++++++++++++++++
 tb/tb_ifu_bpu_gen2.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_bpu_gen2.sv
// ifu_bpu_gen2 - second-generation IFU branch prediction unit.
//
// Sits between the IFU mini-decoder and the IFU PC adder and produces, in
// the decode cycle, the PC adder operands and the predicted-taken flag.
//   - Conditional branches: 2-bit saturating counter BHT indexed by PC
//     word bits. Strong states decide the prediction; weak states fall back
//     to the static backward-taken rule.
//   - JAL: always taken, pc + imm.
//   - JALR: always taken. The base comes from x0 (zero), the RAS top
//     (x1 with a non-empty stack), the x1 forwarding port, or a regfile
//     read through a small IDLE/RDRF state machine for any other rs1.
//   - Circular return address stack with saturating count. A flush empties
//     it by clearing the count; the write pointer is held.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   pc, dec_*            decoded instruction and its PC
//   jalr_rs1_dep         pending write to the JALR rs1 (x1 or xn)
//   ir_valid_clr         IR cleared this cycle, dependency resolves
//   rf2bpu_x1/rf2bpu_rs1 x1 value / rs1 value read one cycle after request
//   upd_valid/pc/taken   branch resolution from the EXU (trains the BHT)
//   bpu_flush            pipeline flush, empties the RAS
//   bpu2rf_rs1_ena       regfile read request for the JALR rs1
//   bpu_wait             IFU stall
//   prdt_taken           predicted taken
//   prdt_pc_add_op1/op2  PC adder operands
module ifu_bpu_gen2 #(
  parameter int PC_SIZE     = 32,
  parameter int XLEN        = 32,
  parameter int RFIDX_WIDTH = 5,
  parameter int BHT_DEPTH   = 64,
  parameter int RAS_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PC_SIZE-1:0]     pc,
  input  logic                   dec_i_valid,
  input  logic                   dec_jal,
  input  logic                   dec_jalr,
  input  logic                   dec_bxx,
  input  logic [XLEN-1:0]        dec_bjp_imm,
  input  logic [RFIDX_WIDTH-1:0] dec_jalr_rs1idx,
  input  logic [RFIDX_WIDTH-1:0] dec_rdidx,
  input  logic                   jalr_rs1_dep,
  input  logic                   ir_valid_clr,
  input  logic [XLEN-1:0]        rf2bpu_x1,
  input  logic [XLEN-1:0]        rf2bpu_rs1,
  input  logic                   upd_valid,
  input  logic [PC_SIZE-1:0]     upd_pc,
  input  logic                   upd_taken,
  input  logic                   bpu_flush,
  output logic                   bpu2rf_rs1_ena,
  output logic                   bpu_wait,
  output logic                   prdt_taken,
  output logic [PC_SIZE-1:0]     prdt_pc_add_op1,
  output logic [PC_SIZE-1:0]     prdt_pc_add_op2
);

  localparam int BHT_IW = $clog2(BHT_DEPTH);
  localparam int RAS_PW = $clog2(RAS_DEPTH);
  localparam int RAS_CW = RAS_PW + 1;

  typedef enum logic {ST_IDLE, ST_RDRF} bpu_state_t;

  bpu_state_t         state_reg;
  logic [PC_SIZE-1:0] ras_mem [RAS_DEPTH];
  logic [RAS_PW-1:0]  ras_wptr_reg;
  logic [RAS_CW-1:0]  ras_cnt_reg;
  logic [1:0]         bht_cnt [BHT_DEPTH];

  // ---------------------------------------------------------------
  // Instruction classification
  // ---------------------------------------------------------------
  logic rs1_x0, rs1_x1, rs1_xn, link, ret;
  assign rs1_x0 = (dec_jalr_rs1idx == RFIDX_WIDTH'(0));
  assign rs1_x1 = (dec_jalr_rs1idx == RFIDX_WIDTH'(1));
  assign rs1_xn = ~rs1_x0 & ~rs1_x1;
  assign link   = (dec_rdidx == RFIDX_WIDTH'(1));
  assign ret    = dec_jalr & rs1_x1 & ~link;

  logic              ras_empty, ras_use;
  logic [RAS_PW-1:0] ras_top_ptr;
  logic [PC_SIZE-1:0] ras_top;
  assign ras_empty   = (ras_cnt_reg == '0);
  assign ras_top_ptr = ras_wptr_reg - RAS_PW'(1);
  assign ras_top     = ras_mem[ras_top_ptr];
  // Any JALR through x1 takes its base from the stack when one is there,
  // both for plain returns and for link-and-return (coroutine) jumps.
  assign ras_use     = dec_jalr & rs1_x1 & ~ras_empty;

  // ---------------------------------------------------------------
  // Stalls and register-read request
  // ---------------------------------------------------------------
  logic dep_pending, x1_stall, xn_req, dec_fire;
  assign dep_pending    = jalr_rs1_dep & ~ir_valid_clr;
  assign x1_stall       = dec_i_valid & dec_jalr & rs1_x1 & ~ras_use & dep_pending;
  // In RDRF the rs1 value is already on rf2bpu_rs1, so no stall there.
  assign xn_req         = (state_reg == ST_IDLE) & dec_i_valid & dec_jalr & rs1_xn;
  assign bpu2rf_rs1_ena = xn_req & ~dep_pending;
  assign bpu_wait       = x1_stall | xn_req;
  assign dec_fire       = dec_i_valid & ~bpu_wait;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (xn_req && !dep_pending) state_reg <= ST_RDRF;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Branch history table: one saturating counter per entry
  // ---------------------------------------------------------------
  logic [BHT_IW-1:0] dec_idx, upd_idx;
  assign dec_idx = pc[BHT_IW+1:2];
  assign upd_idx = upd_pc[BHT_IW+1:2];

  logic unused_upd_pc_bits;
  assign unused_upd_pc_bits = ^{upd_pc[PC_SIZE-1:BHT_IW+2], upd_pc[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
      logic [1:0] cnt_reg;
      logic [1:0] cnt_next;
      logic       upd_hit;

      assign upd_hit = upd_valid & (upd_idx == BHT_IW'(gi));

      always_comb begin
        cnt_next = cnt_reg;
        if (upd_taken) begin
          if (cnt_reg != 2'b11) cnt_next = cnt_reg + 2'b01;
        end else begin
          if (cnt_reg != 2'b00) cnt_next = cnt_reg - 2'b01;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)         cnt_reg <= 2'b01;
        else if (upd_hit) cnt_reg <= cnt_next;
      end

      assign bht_cnt[gi] = cnt_reg;
    end
  endgenerate

  // ---------------------------------------------------------------
  // Return address stack
  // ---------------------------------------------------------------
  logic [PC_SIZE-1:0] pc_plus4;
  logic ras_push, ras_ovwr, ras_pop;
  assign pc_plus4 = pc + PC_SIZE'(4);
  assign ras_push = dec_fire & link & (dec_jal | (dec_jalr & ~ras_use));
  assign ras_ovwr = dec_fire & link & ras_use;
  assign ras_pop  = dec_fire & ret & ~ras_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
      ras_wptr_reg <= '0;
      ras_cnt_reg  <= '0;
    end else if (bpu_flush) begin
      ras_cnt_reg <= '0;
    end else if (ras_push) begin
      // A full stack wraps and overwrites its oldest entry.
      ras_mem[ras_wptr_reg] <= pc_plus4;
      ras_wptr_reg          <= ras_wptr_reg + RAS_PW'(1);
      if (ras_cnt_reg != RAS_CW'(RAS_DEPTH)) ras_cnt_reg <= ras_cnt_reg + RAS_CW'(1);
    end else if (ras_ovwr) begin
      ras_mem[ras_top_ptr] <= pc_plus4;
    end else if (ras_pop) begin
      ras_wptr_reg <= ras_top_ptr;
      ras_cnt_reg  <= ras_cnt_reg - RAS_CW'(1);
    end
  end

  // ---------------------------------------------------------------
  // Prediction outputs
  // ---------------------------------------------------------------
  logic [PC_SIZE-1:0] imm_ext;
  logic [1:0]         bxx_cnt;
  assign imm_ext = PC_SIZE'($signed(dec_bjp_imm));
  assign bxx_cnt = bht_cnt[dec_idx];

  always_comb begin
    prdt_taken      = 1'b0;
    prdt_pc_add_op1 = '0;
    prdt_pc_add_op2 = '0;
    if (dec_bxx) begin
      prdt_pc_add_op1 = pc;
      prdt_pc_add_op2 = imm_ext;
      if (bxx_cnt == 2'b11)      prdt_taken = 1'b1;
      else if (bxx_cnt == 2'b00) prdt_taken = 1'b0;
      else                       prdt_taken = dec_bjp_imm[XLEN-1];
    end else if (dec_jal) begin
      prdt_taken      = 1'b1;
      prdt_pc_add_op1 = pc;
      prdt_pc_add_op2 = imm_ext;
    end else if (dec_jalr) begin
      prdt_taken      = 1'b1;
      prdt_pc_add_op2 = imm_ext;
      if (rs1_x0)       prdt_pc_add_op1 = '0;
      else if (ras_use) prdt_pc_add_op1 = ras_top;
      else if (rs1_x1)  prdt_pc_add_op1 = PC_SIZE'(rf2bpu_x1);
      else              prdt_pc_add_op1 = PC_SIZE'(rf2bpu_rs1);
    end
  end

endmodule

// File: tb/tb_ifu_bpu_gen2.sv
// Self-checking bench for ifu_bpu_gen2: directed scenarios followed by a
// randomized phase, all compared against a queue/array reference model.
module tb_ifu_bpu_gen2;

  localparam int PC_SIZE     = 32;
  localparam int XLEN        = 32;
  localparam int RFIDX_WIDTH = 5;
  localparam int BHT_DEPTH   = 64;
  localparam int RAS_DEPTH   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] pc;
  logic        dec_i_valid, dec_jal, dec_jalr, dec_bxx;
  logic [31:0] dec_bjp_imm;
  logic [4:0]  dec_jalr_rs1idx, dec_rdidx;
  logic        jalr_rs1_dep, ir_valid_clr;
  logic [31:0] rf2bpu_x1, rf2bpu_rs1;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken, bpu_flush;
  logic        bpu2rf_rs1_ena, bpu_wait, prdt_taken;
  logic [31:0] prdt_pc_add_op1, prdt_pc_add_op2;

  ifu_bpu_gen2 #(
    .PC_SIZE(PC_SIZE), .XLEN(XLEN), .RFIDX_WIDTH(RFIDX_WIDTH),
    .BHT_DEPTH(BHT_DEPTH), .RAS_DEPTH(RAS_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .pc(pc),
    .dec_i_valid(dec_i_valid), .dec_jal(dec_jal), .dec_jalr(dec_jalr), .dec_bxx(dec_bxx),
    .dec_bjp_imm(dec_bjp_imm), .dec_jalr_rs1idx(dec_jalr_rs1idx), .dec_rdidx(dec_rdidx),
    .jalr_rs1_dep(jalr_rs1_dep), .ir_valid_clr(ir_valid_clr),
    .rf2bpu_x1(rf2bpu_x1), .rf2bpu_rs1(rf2bpu_rs1),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .bpu_flush(bpu_flush),
    .bpu2rf_rs1_ena(bpu2rf_rs1_ena), .bpu_wait(bpu_wait), .prdt_taken(prdt_taken),
    .prdt_pc_add_op1(prdt_pc_add_op1), .prdt_pc_add_op2(prdt_pc_add_op2)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model state
  int          bht_m [BHT_DEPTH];
  logic [31:0] ras_q [$];
  bit          m_rdrf;   // a read request was granted last cycle

  logic        exp_taken, exp_wait, exp_ena;
  logic [31:0] exp_op1, exp_op2;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    foreach (bht_m[i]) bht_m[i] = 1;
    ras_q.delete();
    m_rdrf = 1'b0;
  endtask

  task automatic model_predict();
    int c;
    bit ras_ok, xn;
    exp_taken = 1'b0; exp_wait = 1'b0; exp_ena = 1'b0;
    exp_op1 = 32'h0;  exp_op2 = 32'h0;
    xn     = (dec_jalr_rs1idx > 5'd1);
    ras_ok = (dec_jalr_rs1idx == 5'd1) && (ras_q.size() > 0);
    if (dec_bxx) begin
      c = bht_m[(pc >> 2) % BHT_DEPTH];
      exp_op1 = pc; exp_op2 = dec_bjp_imm;
      exp_taken = (c == 3) ? 1'b1 : (c == 0) ? 1'b0 : dec_bjp_imm[31];
    end else if (dec_jal) begin
      exp_taken = 1'b1; exp_op1 = pc; exp_op2 = dec_bjp_imm;
    end else if (dec_jalr) begin
      exp_taken = 1'b1; exp_op2 = dec_bjp_imm;
      if (dec_jalr_rs1idx == 5'd0)      exp_op1 = 32'h0;
      else if (ras_ok)                  exp_op1 = ras_q[ras_q.size()-1];
      else if (dec_jalr_rs1idx == 5'd1) exp_op1 = rf2bpu_x1;
      else                              exp_op1 = rf2bpu_rs1;
    end
    if (dec_i_valid && dec_jalr) begin
      if (dec_jalr_rs1idx == 5'd1 && !ras_ok && jalr_rs1_dep && !ir_valid_clr) exp_wait = 1'b1;
      if (xn && !m_rdrf) begin
        exp_wait = 1'b1;
        exp_ena  = !(jalr_rs1_dep && !ir_valid_clr);
      end
    end
  endtask

  task automatic ras_push(input logic [31:0] v);
    ras_q.push_back(v);
    if (ras_q.size() > RAS_DEPTH) void'(ras_q.pop_front());
  endtask

  // Advance one clock and apply the architectural effects to the model.
  task automatic tick();
    bit fire, link;
    int idx;
    model_predict();
    fire = dec_i_valid && !exp_wait;
    link = (dec_rdidx == 5'd1);
    @(posedge clk);
    if (rst) begin
      if (upd_valid) begin
        idx = (upd_pc >> 2) % BHT_DEPTH;
        if (upd_taken) bht_m[idx] = (bht_m[idx] == 3) ? 3 : bht_m[idx] + 1;
        else           bht_m[idx] = (bht_m[idx] == 0) ? 0 : bht_m[idx] - 1;
      end
      if (bpu_flush) ras_q.delete();
      else if (fire) begin
        if (dec_jal && link) ras_push(pc + 32'd4);
        else if (dec_jalr && link) begin
          if (dec_jalr_rs1idx == 5'd1 && ras_q.size() > 0) ras_q[ras_q.size()-1] = pc + 32'd4;
          else ras_push(pc + 32'd4);
        end else if (dec_jalr && dec_jalr_rs1idx == 5'd1 && ras_q.size() > 0)
          void'(ras_q.pop_back());
      end
      m_rdrf = exp_ena;
    end
    #1;
    cyc++;
  endtask

  task automatic settle_and_check();
    #1;
    model_predict();
    check_val("prdt_taken", prdt_taken, exp_taken);
    check_val("bpu_wait", bpu_wait, exp_wait);
    check_val("rs1_ena", bpu2rf_rs1_ena, exp_ena);
    check_val("op1", prdt_pc_add_op1, exp_op1);
    check_val("op2", prdt_pc_add_op2, exp_op2);
    $display("cyc %0d: v=%0b jal=%0b jalr=%0b bxx=%0b pc=%h rs1=%0d rd=%0d -> taken=%0b wait=%0b ena=%0b op1=%h op2=%h",
             cyc, dec_i_valid, dec_jal, dec_jalr, dec_bxx, pc, dec_jalr_rs1idx, dec_rdidx,
             prdt_taken, bpu_wait, bpu2rf_rs1_ena, prdt_pc_add_op1, prdt_pc_add_op2);
  endtask

  task automatic clear_inputs();
    pc = '0; dec_i_valid = 0; dec_jal = 0; dec_jalr = 0; dec_bxx = 0;
    dec_bjp_imm = '0; dec_jalr_rs1idx = '0; dec_rdidx = '0;
    jalr_rs1_dep = 0; ir_valid_clr = 0; rf2bpu_x1 = '0; rf2bpu_rs1 = '0;
    upd_valid = 0; upd_pc = '0; upd_taken = 0; bpu_flush = 0;
  endtask

  task automatic set_dec(input bit j, input bit jr, input bit b, input logic [31:0] p,
                         input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rd);
    dec_i_valid = 1; dec_jal = j; dec_jalr = jr; dec_bxx = b;
    pc = p; dec_bjp_imm = imm; dec_jalr_rs1idx = rs1; dec_rdidx = rd;
  endtask

  task automatic idle_dec();
    dec_i_valid = 0; dec_jal = 0; dec_jalr = 0; dec_bxx = 0;
  endtask

  initial begin
    int waits, enas;
    bit hold;
    int r;
    logic [31:0] m;

    clear_inputs();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset-state outputs with all inputs low
    settle_and_check();
    check_val("rst_taken", prdt_taken, 1'b0);
    check_val("rst_wait", bpu_wait, 1'b0);
    check_val("rst_op1", prdt_pc_add_op1, 32'h0);
    rst = 1'b1;
    tick();

    // Weak counters fall back to the static backward-taken rule
    set_dec(0, 0, 1, 32'h100, 32'd8, 5'd0, 5'd0);
    settle_and_check();
    check_val("bxx_fwd_weak", prdt_taken, 1'b0);
    dec_bjp_imm = -32'd8;
    settle_and_check();
    check_val("bxx_bwd_weak", prdt_taken, 1'b1);
    tick();

    // BHT training at 0x100
    idle_dec();
    upd_valid = 1; upd_pc = 32'h100; upd_taken = 1;
    settle_and_check(); tick();
    settle_and_check(); tick();
    upd_valid = 0;
    set_dec(0, 0, 1, 32'h100, 32'd8, 5'd0, 5'd0);
    settle_and_check();
    check_val("bht_strong_fwd", prdt_taken, 1'b1);
    // Third update lands in the same cycle as a read: read sees old value
    upd_valid = 1;
    settle_and_check();
    check_val("bht_same_cycle", prdt_taken, 1'b1);
    tick();
    upd_valid = 0;
    settle_and_check();
    check_val("bht_saturate", prdt_taken, 1'b1);
    tick();
    set_dec(0, 0, 1, 32'h200, 32'd8, 5'd0, 5'd0);
    settle_and_check();
    check_val("bht_alias_200", prdt_taken, 1'b1);
    pc = 32'h104;
    settle_and_check();
    check_val("bht_other_idx", prdt_taken, 1'b0);
    tick();

    // Call / return
    set_dec(1, 0, 0, 32'h80, 32'h40, 5'd0, 5'd1);
    settle_and_check(); tick();
    set_dec(0, 1, 0, 32'hC0, 32'h10, 5'd1, 5'd0);
    rf2bpu_x1 = 32'hDEAD;
    settle_and_check();
    check_val("ret_ras_op1", prdt_pc_add_op1, 32'h84);
    check_val("ret_ras_op2", prdt_pc_add_op2, 32'h10);
    tick();
    settle_and_check();
    check_val("ret_empty_x1", prdt_pc_add_op1, 32'hDEAD);
    jalr_rs1_dep = 1;
    settle_and_check();
    check_val("x1_dep_stall", bpu_wait, 1'b1);
    jalr_rs1_dep = 0;
    tick();

    // RAS wrap: RAS_DEPTH+1 calls, then pops in LIFO order
    for (int k = 1; k <= RAS_DEPTH + 1; k++) begin
      set_dec(1, 0, 0, 32'h10 * k, 32'h100, 5'd0, 5'd1);
      settle_and_check(); tick();
    end
    rf2bpu_x1 = 32'hBEEF;
    for (int i = 1; i <= RAS_DEPTH; i++) begin
      set_dec(0, 1, 0, 32'h400, 32'h0, 5'd1, 5'd0);
      settle_and_check();
      check_val("ras_lifo", prdt_pc_add_op1, 32'h10 * (RAS_DEPTH + 2 - i) + 32'd4);
      tick();
    end
    settle_and_check();
    check_val("ras_oldest_lost", prdt_pc_add_op1, 32'hBEEF);
    tick();

    // Flush empties the stack, and wins over a same-cycle push
    set_dec(1, 0, 0, 32'h300, 32'h8, 5'd0, 5'd1);
    settle_and_check(); tick();
    idle_dec(); bpu_flush = 1;
    settle_and_check(); tick();
    set_dec(1, 0, 0, 32'h310, 32'h8, 5'd0, 5'd1);
    settle_and_check(); tick();
    bpu_flush = 0;
    set_dec(0, 1, 0, 32'h500, 32'h0, 5'd1, 5'd0);
    settle_and_check();
    check_val("flush_ret_x1", prdt_pc_add_op1, 32'hBEEF);
    tick();

    // JALR through x5: two dependency cycles, then resolve
    waits = 0; enas = 0;
    set_dec(0, 1, 0, 32'h600, 32'h20, 5'd5, 5'd0);
    jalr_rs1_dep = 1; rf2bpu_rs1 = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) ir_valid_clr = 1;
      settle_and_check();
      waits += int'(bpu_wait); enas += int'(bpu2rf_rs1_ena);
      tick();
    end
    jalr_rs1_dep = 0; ir_valid_clr = 0; rf2bpu_rs1 = 32'h4000;
    settle_and_check();
    check_val("xn_op1", prdt_pc_add_op1, 32'h4000);
    check_val("xn_wait_low", bpu_wait, 1'b0);
    waits += int'(bpu_wait); enas += int'(bpu2rf_rs1_ena);
    check_val("xn_wait_cycles", waits, 3);
    check_val("xn_ena_pulses", enas, 1);
    tick();
    idle_dec();

    // Reset while in RDRF
    set_dec(0, 1, 0, 32'h700, 32'h0, 5'd7, 5'd0);
    settle_and_check();
    check_val("rdrf_req", bpu2rf_rs1_ena, 1'b1);
    tick();
    idle_dec();
    rst = 1'b0;
    model_reset();
    settle_and_check();
    check_val("mid_rst_wait", bpu_wait, 1'b0);
    check_val("mid_rst_ena", bpu2rf_rs1_ena, 1'b0);
    tick();
    rst = 1'b1;
    settle_and_check(); tick();
    // A fresh xn JALR must start from IDLE (stall + request)
    set_dec(0, 1, 0, 32'h700, 32'h0, 5'd7, 5'd0);
    settle_and_check();
    check_val("post_rst_idle_wait", bpu_wait, 1'b1);
    check_val("post_rst_idle_ena", bpu2rf_rs1_ena, 1'b1);
    tick();
    settle_and_check(); tick();
    idle_dec();

    // Randomized phase
    hold = 0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        r = $urandom_range(0, 3);
        m = 32'($urandom_range(0, 255)) << 2;
        set_dec(r == 2, r == 3, r == 1, 32'($urandom_range(0, 127)) << 2,
                ($urandom_range(0, 1) != 0) ? m : -m, 5'd0, 5'd0);
        r = $urandom_range(0, 5);
        dec_jalr_rs1idx = (r == 0) ? 5'd0 : (r < 3) ? 5'd1 : 5'($urandom_range(2, 31));
        r = $urandom_range(0, 2);
        dec_rdidx = (r == 0) ? 5'd1 : (r == 1) ? 5'd0 : 5'($urandom_range(2, 31));
        dec_i_valid = ($urandom_range(0, 9) != 0);
      end
      jalr_rs1_dep = ($urandom_range(0, 3) == 0);
      ir_valid_clr = ($urandom_range(0, 2) == 0);
      rf2bpu_x1    = $urandom;
      rf2bpu_rs1   = $urandom;
      upd_valid    = ($urandom_range(0, 1) != 0);
      upd_pc       = 32'($urandom_range(0, 127)) << 2;
      upd_taken    = ($urandom_range(0, 1) != 0);
      bpu_flush    = ($urandom_range(0, 19) == 0);
      settle_and_check();
      hold = bpu_wait && ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
